mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle main control unit for the MIPS datapath: a Moore FSM that sequences
//  the datapath through FETCH/DECODE/EXEC/MEM/WB. Replaces the single-cycle opcode decoder.
//  Adds R-type funct decode, a memory ready handshake with a timeout, and a sticky illegal-op trap.
//  Sits between the IR/ALU flags and every datapath mux, register-file and memory enable.
// PARAMETERS
//  MEM_TIMEOUT      15  max cycles a memory state waits for mem_ready before trapping (>=1)
//  TRAP_ON_ILLEGAL  1   1: illegal op/funct -> TRAP (sticky); 0: treated as NOP, back to FETCH
//  ALUCW            4   width of alu_ctrl
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active high
//  op         in   6      IR[31:26], valid from DECODE onward
//  funct      in   6      IR[5:0]
//  mem_ready  in   1      memory completes the current access this cycle
//  zero       in   1      ALU result == 0
//  neg        in   1      ALU result sign bit
//  pc_write   out  1      PC load enable
//  pc_src     out  2      0 ALU (PC+4), 1 ALUOut (branch target), 2 jump target
//  ir_write   out  1      IR load enable
//  iord       out  1      memory address: 0 PC, 1 ALUOut
//  mem_read   out  2      0 none, 1 byte, 2 half, 3 word
//  mem_write  out  2      0 none, 1 byte, 2 half, 3 word
//  reg_dst    out  2      0 rt, 1 rd, 2 $31
//  mem_to_reg out  2      0 ALUOut, 1 MDR, 2 PC
//  reg_write  out  1      register file write enable
//  alu_src_a  out  1      0 PC, 1 rs
//  alu_src_b  out  2      0 rt, 1 const 4, 2 imm, 3 imm<<2
//  alu_ctrl   out  ALUCW  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor, 1000 lui
//  inm        out  1      immediate path selected (alu_src_b==2)
//  state      out  4      current state encoding (debug)
//  illegal    out  1      sticky: trap taken
// BEHAVIOUR
//  Reset: state<=FETCH, timeout counter<=0, illegal<=0. All outputs are 0 while rst is high.
//  States: FETCH=0 DECODE=1 EXEC_R=2 EXEC_I=3 ADDR=4 MEM_RD=5 MEM_WB=6 MEM_WR=7 BRANCH=8 JUMP=9 ALU_WB=10 TRAP=11.
//  FETCH:  iord=0, mem_read=3, src_a=0, src_b=1, alu_ctrl=add. While mem_ready=0: stay, no enables.
//          On mem_ready: ir_write=1, pc_write=1, pc_src=0 in the same cycle -> DECODE.
//  DECODE: src_a=0, src_b=3, add (branch target into ALUOut). Next state by op:
//          000000 -> EXEC_R; 001000/001100/001101/001010/001111 -> EXEC_I;
//          100000/100001/100011/101000/101001/101011 -> ADDR; 000100/000101/000001 -> BRANCH;
//          000010/000011 -> JUMP; any other op -> TRAP (or FETCH if TRAP_ON_ILLEGAL=0).
//  EXEC_R: src_a=1, src_b=0. funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt,
//          100111 nor -> ALU_WB with reg_dst=1. Unknown funct -> handled like an illegal op.
//  EXEC_I: src_a=1, src_b=2, inm=1. addi add, andi and, ori or, slti slt, lui 1000 -> ALU_WB, reg_dst=0.
//  ALU_WB: reg_write=1, mem_to_reg=0, reg_dst held from the EXEC state -> FETCH.
//  ADDR:   src_a=1, src_b=2, add, inm=1. lb/lh/lw -> MEM_RD; sb/sh/sw -> MEM_WR.
//  MEM_RD: iord=1, mem_read=1/2/3 for lb/lh/lw. mem_ready -> MEM_WB.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  MEM_WR: iord=1, mem_write=1/2/3 for sb/sh/sw. mem_ready -> FETCH.
//  BRANCH: src_a=1, src_b=0, sub, pc_src=1. pc_write = beq&zero | bne&~zero | bgez&~neg -> FETCH.
//  JUMP:   pc_src=2, pc_write=1. jal also asserts reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH.
//  TRAP:   all enables 0, illegal=1. Only rst leaves TRAP.
//  Timeout: the counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each waiting cycle.
//          mem_read/mem_write stay asserted while waiting.
//          Count==MEM_TIMEOUT with mem_ready=0 -> TRAP (sticky even if TRAP_ON_ILLEGAL=0).
//          mem_ready in the same cycle as the timeout wins: normal transition.
//  Latency with mem_ready tied to 1: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3.
//  rst mid-instruction: aborts next edge to FETCH; no write enable is asserted in the reset cycle.
// TESTING
//  1. mem_ready=1, op=000000, funct=100010 -> states 0,1,2,10,0; alu_ctrl=0110 in EXEC_R;
//     reg_write=1 and reg_dst=1 only in ALU_WB.
//  2. op=100011 (lw), mem_ready low 3 cycles in MEM_RD -> mem_read=3, iord=1 held 4 cycles;
//     MEM_WB: reg_write=1, mem_to_reg=1; 8 cycles total.
//  3. op=000100: zero=1 -> pc_write=1, pc_src=1 in BRANCH. zero=0 -> pc_write=0.
//     op=000001 with neg=1 -> pc_write=0.
//  4. op=000011 (jal) -> JUMP: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2.
//  5. op=111111 -> TRAP, illegal=1 held 20 cycles; rst=1 for 1 cycle -> FETCH, illegal=0.
//     With TRAP_ON_ILLEGAL=0 -> back to FETCH, illegal stays 0.
//  6. mem_ready=0 in MEM_WR (sw) for 15 cycles -> TRAP.
//     mem_ready=1 exactly on the 15th waiting cycle -> FETCH, no trap.

Source files
------------

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle main control unit for the MIPS datapath. This is a Moore FSM that
// steps through the FETCH/DECODE/EXEC/MEM/WB phases. Decoding covers R-type
// funct values, a memory ready handshake with a wait timeout, and a sticky
// illegal-operation trap.
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   op, funct    IR[31:26] and IR[5:0]; op is valid from DECODE onward
//   mem_ready    memory completes the current access this cycle
//   zero, neg    ALU result flags used for branch resolution
//   pc_write     PC load enable        pc_src     0 PC+4, 1 ALUOut, 2 jump
//   ir_write     IR load enable        iord       memory address 0 PC, 1 ALUOut
//   mem_read     0 none, 1 byte, 2 half, 3 word
//   mem_write    0 none, 1 byte, 2 half, 3 word
//   reg_dst      0 rt, 1 rd, 2 $31     mem_to_reg 0 ALUOut, 1 MDR, 2 PC
//   reg_write    register file write enable
//   alu_src_a    0 PC, 1 rs            alu_src_b  0 rt, 1 4, 2 imm, 3 imm<<2
//   alu_ctrl     ALU operation code    inm        immediate operand selected
//   state        current state (debug) illegal    sticky trap indicator
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int MEM_TIMEOUT     = 15,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int ALUCW           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             zero,
  input  logic             neg,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic [1:0]       mem_read,
  output logic [1:0]       mem_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALUCW-1:0] alu_ctrl,
  output logic             inm,
  output logic [3:0]       state,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WB = 4'd6,  S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ALU_WB = 4'd10, S_TRAP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI  = 6'b001101, OP_SLTI = 6'b001010, OP_LUI  = 6'b001111,
                         OP_LB   = 6'b100000, OP_LH   = 6'b100001, OP_LW   = 6'b100011,
                         OP_SB   = 6'b101000, OP_SH   = 6'b101001, OP_SW   = 6'b101011,
                         OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_BGEZ = 6'b000001,
                         OP_J    = 6'b000010, OP_JAL  = 6'b000011;

  localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(4'b0000), ALU_OR  = ALUCW'(4'b0001),
                               ALU_ADD = ALUCW'(4'b0010), ALU_SUB = ALUCW'(4'b0110),
                               ALU_SLT = ALUCW'(4'b0111), ALU_NOR = ALUCW'(4'b1100),
                               ALU_LUI = ALUCW'(4'b1000);

  // Where an unknown op/funct goes; only a memory timeout traps unconditionally.
  localparam state_t ILL_NEXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          rdst_q, rdst_d;     // 1: ALU_WB writes rd (R-type), 0: rt (I-type)
  logic          timeout;

  // Access size is encoded in op[1:0] for both the load and the store groups.
  function automatic logic [1:0] mem_size(input logic [1:0] lo);
    case (lo)
      2'b00:   return 2'd1;
      2'b01:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // cnt_q counts completed waiting cycles, so the current one is number cnt_q+1.
  assign timeout = (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    rdst_d     = rdst_q;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 2'd0;
    mem_write  = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctrl   = '0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 2'd3;
        alu_src_b = 2'd1;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_ctrl  = ALU_ADD;
        case (op)
          OP_R:                                     state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_EXEC_I;
          OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW:  state_d = S_ADDR;
          OP_BEQ, OP_BNE, OP_BGEZ:                  state_d = S_BRANCH;
          OP_J, OP_JAL:                             state_d = S_JUMP;
          default:                                  state_d = ILL_NEXT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        rdst_d    = 1'b1;
        state_d   = S_ALU_WB;
        case (funct)
          6'b100000: alu_ctrl = ALU_ADD;
          6'b100010: alu_ctrl = ALU_SUB;
          6'b100100: alu_ctrl = ALU_AND;
          6'b100101: alu_ctrl = ALU_OR;
          6'b101010: alu_ctrl = ALU_SLT;
          6'b100111: alu_ctrl = ALU_NOR;
          default:   state_d  = ILL_NEXT;
        endcase
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        rdst_d    = 1'b0;
        state_d   = S_ALU_WB;
        case (op)
          OP_ADDI: alu_ctrl = ALU_ADD;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_LUI:  alu_ctrl = ALU_LUI;
          default: state_d  = ILL_NEXT;
        endcase
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = rdst_q ? 2'd1 : 2'd0;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = ALU_ADD;
        case (op)
          OP_LB, OP_LH, OP_LW: state_d = S_MEM_RD;
          OP_SB, OP_SH, OP_SW: state_d = S_MEM_WR;
          default:             state_d = ILL_NEXT;
        endcase
      end
      S_MEM_RD, S_MEM_WR: begin
        iord = 1'b1;
        if (state_q == S_MEM_RD) mem_read  = mem_size(op[1:0]);
        else                     mem_write = mem_size(op[1:0]);
        if (mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'd1;
        pc_write  = ((op == OP_BEQ) &&  zero) ||
                    ((op == OP_BNE) && !zero) ||
                    ((op == OP_BGEZ) && !neg);
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
        if (op == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    illegal_d = illegal_q | (state_d == S_TRAP);

    // Nothing may be enabled in a reset cycle, even mid-instruction.
    if (rst) begin
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 2'd0;
      mem_write  = 2'd0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_ctrl   = '0;
    end
  end

  assign inm     = (alu_src_b == 2'd2);
  assign state   = rst ? 4'd0 : state_q;
  assign illegal = illegal_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      rdst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      rdst_q    <= rdst_d;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Bench for mc_control_fsm. One instance traps on illegal ops and the other
// treats them as NOPs. Both instances share the same stimulus, and the bench
// observes one of them at a time. For each instruction a reference model
// builds the list of control words expected cycle by cycle. It works from the
// instruction class, the stall counts and the timeout limit.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  localparam int T = 15;

  localparam logic [5:0] R    = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100,
                         ORI  = 6'b001101, SLTI = 6'b001010, LUI  = 6'b001111,
                         LB   = 6'b100000, LH   = 6'b100001, LW   = 6'b100011,
                         SB   = 6'b101000, SH   = 6'b101001, SW   = 6'b101011,
                         BEQ  = 6'b000100, BNE  = 6'b000101, BGEZ = 6'b000001,
                         J    = 6'b000010, JAL  = 6'b000011;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100,
                         A_LUI = 4'b1000;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic [1:0] mem_read;
    logic [1:0] mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       inm;
    logic [3:0] state;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       mem_ready, zero, neg;

  logic       a_pc_write, a_ir_write, a_iord, a_reg_write, a_alu_src_a, a_inm, a_illegal;
  logic [1:0] a_pc_src, a_mem_read, a_mem_write, a_reg_dst, a_mem_to_reg, a_alu_src_b;
  logic [3:0] a_alu_ctrl, a_state;
  logic       b_pc_write, b_ir_write, b_iord, b_reg_write, b_alu_src_a, b_inm, b_illegal;
  logic [1:0] b_pc_src, b_mem_read, b_mem_write, b_reg_dst, b_mem_to_reg, b_alu_src_b;
  logic [3:0] b_alu_ctrl, b_state;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(T), .TRAP_ON_ILLEGAL(1'b1), .ALUCW(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
    .zero(zero), .neg(neg), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .ir_write(a_ir_write), .iord(a_iord), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_ctrl(a_alu_ctrl), .inm(a_inm), .state(a_state), .illegal(a_illegal));

  mc_control_fsm #(.MEM_TIMEOUT(T), .TRAP_ON_ILLEGAL(1'b0), .ALUCW(4)) dut_n (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
    .zero(zero), .neg(neg), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .ir_write(b_ir_write), .iord(b_iord), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_ctrl(b_alu_ctrl), .inm(b_inm), .state(b_state), .illegal(b_illegal));

  ctl_t obs_a, obs_b;
  assign obs_a = {a_pc_write, a_pc_src, a_ir_write, a_iord, a_mem_read, a_mem_write,
                  a_reg_dst, a_mem_to_reg, a_reg_write, a_alu_src_a, a_alu_src_b,
                  a_alu_ctrl, a_inm, a_state, a_illegal};
  assign obs_b = {b_pc_write, b_pc_src, b_ir_write, b_iord, b_mem_read, b_mem_write,
                  b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b,
                  b_alu_ctrl, b_inm, b_state, b_illegal};

  int   total = 0;
  int   fails = 0;
  bit   sel = 1'b0;
  int   trap_hold = 3;
  ctl_t exp_q[$];
  bit   mr_q[$];

  logic [5:0] ops [17] = '{R, ADDI, ANDI, ORI, SLTI, LUI, LB, LH, LW, SB, SH, SW,
                           BEQ, BNE, BGEZ, J, JAL};
  logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

  task automatic chk(input ctl_t o, input ctl_t e, input string tag);
    total++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h (state %0d) required %h (state %0d)", tag, o, o.state, e, e.state);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic ctl_t idle(input int st);
    ctl_t c = '0;
    c.state = 4'(st);
    return c;
  endfunction

  task automatic push(input ctl_t c, input bit mr);
    exp_q.push_back(c);
    mr_q.push_back(mr);
  endtask

  task automatic push_any(input ctl_t c);
    push(c, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_trap();
    ctl_t c;
    c = idle(11);
    c.illegal = 1'b1;
    for (int i = 0; i < trap_hold; i++) push_any(c);
  endtask

  // stalls = number of cycles with mem_ready low; reaching T of them traps.
  task automatic add_wait(input ctl_t busy, input ctl_t done, input int stalls, output bit trapped);
    trapped = 1'b0;
    for (int w = 1; w <= T; w++) begin
      if (w > stalls) begin
        push(done, 1'b1);
        return;
      end
      push(busy, 1'b0);
      if (w == T) begin
        trapped = 1'b1;
        push_trap();
        return;
      end
    end
  endtask

  function automatic int msize(input logic [5:0] o);
    case (o)
      LB, SB:  return 1;
      LH, SH:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model(input bit ten, input logic [5:0] o, input logic [5:0] f, input bit z,
                       input bit n, input int fs, input int ms, output bit trapped);
    ctl_t c, d;
    bit   tr, ok, rtype;
    exp_q.delete();
    mr_q.delete();
    trapped = 1'b0;
    c = idle(0); c.mem_read = 2'd3; c.alu_src_b = 2'd1; c.alu_ctrl = A_ADD;
    d = c; d.ir_write = 1'b1; d.pc_write = 1'b1;
    add_wait(c, d, fs, tr);
    if (tr) begin trapped = 1'b1; return; end
    c = idle(1); c.alu_src_b = 2'd3; c.alu_ctrl = A_ADD;
    push_any(c);
    ok = 1'b1;
    rtype = 1'b0;
    if (o == R) begin
      rtype = 1'b1;
      c = idle(2); c.alu_src_a = 1'b1;
      case (f)
        6'b100000: c.alu_ctrl = A_ADD;
        6'b100010: c.alu_ctrl = A_SUB;
        6'b100100: c.alu_ctrl = A_AND;
        6'b100101: c.alu_ctrl = A_OR;
        6'b101010: c.alu_ctrl = A_SLT;
        6'b100111: c.alu_ctrl = A_NOR;
        default:   ok = 1'b0;
      endcase
      push_any(c);
    end else if (o inside {ADDI, ANDI, ORI, SLTI, LUI}) begin
      c = idle(3); c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.inm = 1'b1;
      c.alu_ctrl = (o == ADDI) ? A_ADD : (o == ANDI) ? A_AND : (o == ORI) ? A_OR :
                   (o == SLTI) ? A_SLT : A_LUI;
      push_any(c);
    end else if (o inside {LB, LH, LW, SB, SH, SW}) begin
      c = idle(4); c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_ctrl = A_ADD; c.inm = 1'b1;
      push_any(c);
      if (o inside {LB, LH, LW}) begin
        c = idle(5); c.iord = 1'b1; c.mem_read = 2'(msize(o));
        add_wait(c, c, ms, tr);
        if (tr) begin trapped = 1'b1; return; end
        c = idle(6); c.reg_write = 1'b1; c.mem_to_reg = 2'd1;
        push_any(c);
      end else begin
        c = idle(7); c.iord = 1'b1; c.mem_write = 2'(msize(o));
        add_wait(c, c, ms, tr);
        if (tr) begin trapped = 1'b1; return; end
      end
      return;
    end else if (o inside {BEQ, BNE, BGEZ}) begin
      c = idle(8); c.alu_src_a = 1'b1; c.alu_ctrl = A_SUB; c.pc_src = 2'd1;
      c.pc_write = ((o == BEQ) && z) || ((o == BNE) && !z) || ((o == BGEZ) && !n);
      push_any(c);
      return;
    end else if (o inside {J, JAL}) begin
      c = idle(9); c.pc_src = 2'd2; c.pc_write = 1'b1;
      if (o == JAL) begin c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
      push_any(c);
      return;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      if (ten) begin trapped = 1'b1; push_trap(); end
      return;
    end
    c = idle(10); c.reg_write = 1'b1; c.reg_dst = rtype ? 2'd1 : 2'd0;
    push_any(c);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    chk(sel ? obs_b : obs_a, '0, name);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic play(input logic [5:0] o, input logic [5:0] f, input bit z, input bit n,
                      input int lim, input string name);
    for (int i = 0; i < exp_q.size() && i < lim; i++) begin
      @(negedge clk);
      if (i == 0) begin op = o; funct = f; zero = z; neg = n; end
      mem_ready = mr_q[i];
      #1;
      chk(sel ? obs_b : obs_a, exp_q[i], $sformatf("%s[%0d]", name, i));
    end
  endtask

  task automatic run(input bit ten, input logic [5:0] o, input logic [5:0] f, input bit z,
                     input bit n, input int fs, input int ms, input int lim, input string name);
    bit tr;
    model(ten, o, f, z, n, fs, ms, tr);
    play(o, f, z, n, lim, name);
    if (tr || lim < exp_q.size()) do_reset({name, "_rst"});
  endtask

  function automatic int rnd_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return 0;
    if (r < 18) return $urandom_range(1, 5);
    if (r == 18) return T - 1;
    return T;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] o, f;
    int lim;
    rst = 1'b1; op = '0; funct = '0; mem_ready = 1'b0; zero = 1'b0; neg = 1'b0;
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1;
      chk(obs_a, '0, "reset_out");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed steps, trapping instance
    run(1, R,    6'b100010, 0, 0, 0, 0, 1000, "sub");
    run(1, R,    6'b100111, 0, 0, 1, 0, 1000, "nor");
    run(1, LUI,  6'b000000, 0, 0, 0, 0, 1000, "lui");
    run(1, LW,   6'b000000, 0, 0, 0, 3, 1000, "lw_stall3");
    run(1, LB,   6'b000000, 0, 0, 0, 0, 1000, "lb");
    run(1, SH,   6'b000000, 0, 0, 0, 2, 1000, "sh");
    run(1, BEQ,  6'b000000, 1, 0, 0, 0, 1000, "beq_taken");
    run(1, BEQ,  6'b000000, 0, 0, 0, 0, 1000, "beq_not");
    run(1, BGEZ, 6'b000000, 0, 1, 0, 0, 1000, "bgez_neg");
    run(1, BNE,  6'b000000, 0, 0, 0, 0, 1000, "bne_taken");
    run(1, JAL,  6'b000000, 0, 0, 0, 0, 1000, "jal");
    run(1, J,    6'b000000, 0, 0, 0, 0, 1000, "j");
    trap_hold = 20;
    run(1, 6'b111111, 6'b000000, 0, 0, 0, 0, 1000, "illegal_op");
    trap_hold = 3;
    run(1, R,    6'b111111, 0, 0, 0, 0, 1000, "illegal_funct");
    run(1, SW,   6'b000000, 0, 0, 0, T, 1000, "sw_timeout");
    run(1, SW,   6'b000000, 0, 0, 0, T - 1, 1000, "sw_ready_last");
    run(1, LW,   6'b000000, 0, 0, 0, T - 1, 1000, "lw_ready_last");
    run(1, ADDI, 6'b000000, 0, 0, T, 0, 1000, "fetch_timeout");
    run(1, ORI,  6'b000000, 0, 0, T - 1, 0, 1000, "fetch_ready_last");
    run(1, LW,   6'b000000, 0, 0, 0, 8, 6, "lw_abort");
    run(1, SLTI, 6'b000000, 0, 0, 0, 0, 1000, "slti_after_abort");

    // randomized instruction stream
    for (int k = 0; k < 200; k++) begin
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      lim = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 4) : 1000;
      run(1, o, f, 1'($urandom), 1'($urandom), rnd_wait(), rnd_wait(), lim,
          $sformatf("rnd%0d_op%b", k, o));
    end

    // non-trapping instance
    sel = 1'b1;
    do_reset("n_reset");
    run(0, 6'b111111, 6'b000000, 0, 0, 0, 0, 1000, "n_illegal_op");
    run(0, R,    6'b000001, 0, 0, 0, 0, 1000, "n_illegal_funct");
    run(0, ADDI, 6'b000000, 0, 0, 0, 0, 1000, "n_addi");
    run(0, SW,   6'b000000, 0, 0, 0, T, 1000, "n_sw_timeout");
    run(0, AND_OP_FIX(), 6'b100100, 0, 0, 0, 0, 1000, "n_and");
    for (int k = 0; k < 60; k++) begin
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      run(0, o, f, 1'($urandom), 1'($urandom), rnd_wait(), rnd_wait(), 1000,
          $sformatf("nrnd%0d_op%b", k, o));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  function automatic logic [5:0] AND_OP_FIX();
    return R;
  endfunction

endmodule
